// File: rtl/hex_clock_display_sequencer.sv
// Sequences six BCD digit writes (sec/min/hour) into the seven-segment decoder register port.
// Build option HOUR_LEADING_ZERO_BLANK_EN blanks the hour tens digit when it is zero.
module hex_clock_display_sequencer #(
  parameter int WRITE_GAP = 0
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iUpdate,
  input  logic [5:0]  iSec,
  input  logic [5:0]  iMin,
  input  logic [4:0]  iHour,
  output logic        oChip_select_n,
  output logic        oWrite_n,
  output logic [2:0]  oAddress,
  output logic [31:0] oData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oRange_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] GapLoad = (WRITE_GAP > 0) ? 4'(WRITE_GAP - 1) : 4'd0;
  localparam logic [3:0] Blank   = 4'hF;

  state_t      stateR, stateNext;
  logic [2:0]  indexR, indexNext;
  logic [3:0]  gapCntR, gapCntNext;
  logic        loadInputs, loadPending;

  logic [5:0]  capSecR, capMinR;
  logic [4:0]  capHourR;
  logic [5:0]  pendSecR, pendMinR;
  logic [4:0]  pendHourR;
  logic        pendingR;
  logic        rangeErrR;

  logic        pendStore;
  logic        inBad, pendBad;
  logic        secOk, minOk, hourOk;
  logic [7:0]  secBcd, minBcd, hourBcd;
  logic [3:0]  digitSel;
  logic [3:0]  hourTens;

  // Compare/subtract binary-to-BCD for values up to 59: {tens, ones}.
  function automatic logic [7:0] toBcd(input logic [5:0] value);
    logic [5:0] rem;
    logic [3:0] tens;
    logic       step;
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 5; i++) begin
      step = (rem >= 6'd10);
      rem  = step ? (rem - 6'd10) : rem;
      tens = tens + {3'd0, step};
    end
    return {tens, rem[3:0]};
  endfunction

  assign inBad   = (iSec > 6'd59) || (iMin > 6'd59) || (iHour > 5'd23);
  assign pendBad = (pendSecR > 6'd59) || (pendMinR > 6'd59) || (pendHourR > 5'd23);
  // A strobe arriving mid-sequence, or in DONE while a restart is already queued, is parked.
  assign pendStore = iUpdate && ((stateR == WRITE) || (stateR == GAP) ||
                                 ((stateR == DONE) && pendingR));

  // Next-state, digit index and gap counter logic.
  always_comb begin
    stateNext   = stateR;
    indexNext   = indexR;
    gapCntNext  = gapCntR;
    loadInputs  = 1'b0;
    loadPending = 1'b0;
    case (stateR)
      IDLE: begin
        if (iUpdate) begin
          loadInputs = 1'b1;
          indexNext  = 3'd0;
          stateNext  = WRITE;
        end else begin
          stateNext  = IDLE;
        end
      end
      WRITE: begin
        if (indexR == 3'd5) begin
          stateNext = DONE;
        end else begin
          indexNext = indexR + 3'd1;
          if (WRITE_GAP > 0) begin
            stateNext  = GAP;
            gapCntNext = GapLoad;
          end else begin
            stateNext  = WRITE;
          end
        end
      end
      GAP: begin
        if (gapCntR == 4'd0) begin
          stateNext  = WRITE;
        end else begin
          gapCntNext = gapCntR - 4'd1;
        end
      end
      DONE: begin
        indexNext = 3'd0;
        if (pendingR) begin
          loadPending = 1'b1;
          stateNext   = WRITE;
        end else if (iUpdate) begin
          loadInputs  = 1'b1;
          stateNext   = WRITE;
        end else begin
          stateNext   = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        indexNext = 3'd0;
      end
    endcase
  end

  // FSM state, digit index and gap counter registers.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      stateR  <= IDLE;
      indexR  <= 3'd0;
      gapCntR <= 4'd0;
    end else begin
      stateR  <= stateNext;
      indexR  <= indexNext;
      gapCntR <= gapCntNext;
    end
  end

  // Capture, pending and sticky range-error registers.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      capSecR   <= 6'd0;
      capMinR   <= 6'd0;
      capHourR  <= 5'd0;
      pendSecR  <= 6'd0;
      pendMinR  <= 6'd0;
      pendHourR <= 5'd0;
      pendingR  <= 1'b0;
      rangeErrR <= 1'b0;
    end else begin
      if (loadPending) begin
        capSecR  <= pendSecR;
        capMinR  <= pendMinR;
        capHourR <= pendHourR;
      end else if (loadInputs) begin
        capSecR  <= iSec;
        capMinR  <= iMin;
        capHourR <= iHour;
      end
      if (pendStore) begin
        pendSecR  <= iSec;
        pendMinR  <= iMin;
        pendHourR <= iHour;
        pendingR  <= 1'b1;
      end else if (loadPending) begin
        pendingR  <= 1'b0;
      end
      if ((loadPending && pendBad) || (loadInputs && inBad)) begin
        rangeErrR <= 1'b1;
      end
    end
  end

  assign secOk   = (capSecR <= 6'd59);
  assign minOk   = (capMinR <= 6'd59);
  assign hourOk  = (capHourR <= 5'd23);
  assign secBcd  = toBcd(capSecR);
  assign minBcd  = toBcd(capMinR);
  assign hourBcd = toBcd({1'b0, capHourR});

`ifdef HOUR_LEADING_ZERO_BLANK_EN
  assign hourTens = (!hourOk || (hourBcd[7:4] == 4'd0)) ? Blank : hourBcd[7:4];
`else
  assign hourTens = hourOk ? hourBcd[7:4] : Blank;
`endif

  // Digit selection by address; out-of-range fields become blank.
  always_comb begin
    digitSel = 4'd0;
    case (indexR)
      3'd0:    digitSel = secOk  ? secBcd[3:0]  : Blank;
      3'd1:    digitSel = secOk  ? secBcd[7:4]  : Blank;
      3'd2:    digitSel = minOk  ? minBcd[3:0]  : Blank;
      3'd3:    digitSel = minOk  ? minBcd[7:4]  : Blank;
      3'd4:    digitSel = hourOk ? hourBcd[3:0] : Blank;
      3'd5:    digitSel = hourTens;
      default: digitSel = 4'd0;
    endcase
  end

  // Registered bus outputs, one cycle behind the FSM state that produces them.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oChip_select_n <= 1'b1;
      oWrite_n       <= 1'b1;
      oAddress       <= 3'd0;
      oData          <= 32'd0;
      oBusy          <= 1'b0;
      oDone          <= 1'b0;
    end else begin
      oChip_select_n <= (stateR != WRITE);
      oWrite_n       <= (stateR != WRITE);
      oAddress       <= (stateR == WRITE) ? indexR : 3'd0;
      oData          <= (stateR == WRITE) ? {28'd0, digitSel} : 32'd0;
      oBusy          <= (stateR == WRITE) || (stateR == GAP);
      oDone          <= (stateR == DONE);
    end
  end

  assign oRange_err = rangeErrR;

endmodule

// File: tb/tb_hex_clock_display_sequencer.sv
// Randomised self-checking bench: a gap-0 and a gap-3 instance checked against a digit/timing model.
module tb_hex_clock_display_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic upd0 = 1'b0;
  logic upd3 = 1'b0;
  logic [5:0] secV = 6'd0;
  logic [5:0] minV = 6'd0;
  logic [4:0] hourV = 5'd0;

  logic cs0, wr0, busy0, done0, rerr0;
  logic [2:0] addr0;
  logic [31:0] data0;
  logic cs3, wr3, busy3, done3, rerr3;
  logic [2:0] addr3;
  logic [31:0] data3;

  wr_t wq0[$], wq3[$], expQ[$];
  int  dq0[$], dq3[$], expDoneQ[$];
  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  bit  rangeModel = 1'b0;

  hex_clock_display_sequencer #(.WRITE_GAP(0)) dut0 (
    .iClk(clk), .iReset_n(rst_n), .iUpdate(upd0),
    .iSec(secV), .iMin(minV), .iHour(hourV),
    .oChip_select_n(cs0), .oWrite_n(wr0), .oAddress(addr0), .oData(data0),
    .oBusy(busy0), .oDone(done0), .oRange_err(rerr0)
  );

  hex_clock_display_sequencer #(.WRITE_GAP(3)) dut3 (
    .iClk(clk), .iReset_n(rst_n), .iUpdate(upd3),
    .iSec(secV), .iMin(minV), .iHour(hourV),
    .oChip_select_n(cs3), .oWrite_n(wr3), .oAddress(addr3), .oData(data3),
    .oBusy(busy3), .oDone(done3), .oRange_err(rerr3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records every write and done pulse with its cycle number.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (!cs0 && !wr0) begin
      w.cyc = 32'(cyc); w.addr = addr0; w.data = data0;
      wq0.push_back(w);
    end
    if (done0) dq0.push_back(cyc);
    if (!cs3 && !wr3) begin
      w.cyc = 32'(cyc); w.addr = addr3; w.data = data3;
      wq3.push_back(w);
    end
    if (done3) dq3.push_back(cyc);
  end

  // Reference model: digits by decimal arithmetic, write n at k+1+n*(g+1).
  function automatic void push_exp(input int s, input int m, input int h, input int k, input int g);
    int  d[6];
    wr_t e;
    d[0] = (s > 59) ? 15 : s % 10;
    d[1] = (s > 59) ? 15 : s / 10;
    d[2] = (m > 59) ? 15 : m % 10;
    d[3] = (m > 59) ? 15 : m / 10;
    d[4] = (h > 23) ? 15 : h % 10;
    d[5] = (h > 23) ? 15 : h / 10;
`ifdef HOUR_LEADING_ZERO_BLANK_EN
    if (h <= 23 && h / 10 == 0) d[5] = 15;
`endif
    for (int n = 0; n < 6; n++) begin
      e.cyc  = 32'(k + 1 + n * (g + 1));
      e.addr = 3'(n);
      e.data = 32'(d[n]);
      expQ.push_back(e);
    end
    expDoneQ.push_back(k + 2 + 5 * (g + 1));
    if (s > 59 || m > 59 || h > 23) rangeModel = 1'b1;
  endfunction

  function automatic void clear_all();
    wq0.delete(); wq3.delete(); dq0.delete(); dq3.delete();
    expQ.delete(); expDoneQ.delete();
  endfunction

  task automatic pulse(input bit useGap, input int s, input int m, input int h, output int k);
    @(negedge clk);
    secV = 6'(s); minV = 6'(m); hourV = 5'(h);
    if (useGap) upd3 = 1'b1;
    else upd0 = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    upd0 = 1'b0;
    upd3 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({cs0, wr0, addr0, busy0, done0, rerr0} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_ctrl actual cs=%b wr=%b addr=%0d busy=%b done=%b rerr=%b required 1 1 0 0 0 0",
               cs0, wr0, addr0, busy0, done0, rerr0);
    end
    tests++;
    if (data0 !== 32'd0) begin
      fails++; $display("FAIL reset_data actual=%h required=0", data0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({cs0, busy0, cs3, busy3} !== 4'b1010) begin
      fails++; $display("FAIL reset_idle actual=%b required=1010", {cs0, busy0, cs3, busy3});
    end
  endtask

  task automatic test_basic();
    int k;
    clear_all();
    pulse(1'b0, 37, 5, 14, k);
    push_exp(37, 5, 14, k, 0);
    repeat (3) @(negedge clk);
    tests++;
    if (busy0 !== 1'b1) begin fails++; $display("FAIL basic_busy actual=%b required=1", busy0); end
    repeat (4) @(negedge clk);
    tests++;
    if ({done0, busy0} !== 2'b10) begin
      fails++; $display("FAIL basic_done_cycle actual done=%b busy=%b required done=1 busy=0", done0, busy0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (wq0.size() != expQ.size()) begin
      fails++; $display("FAIL basic_count actual=%0d required=%0d", wq0.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size(); i++) begin
      tests++;
      if (i >= wq0.size() || wq0[i] !== expQ[i]) begin
        fails++;
        $display("FAIL basic_write%0d actual cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                 i, wq0[i].cyc, wq0[i].addr, wq0[i].data, expQ[i].cyc, expQ[i].addr, expQ[i].data);
      end
    end
    tests++;
    if (dq0.size() != 1 || dq0[0] != expDoneQ[0] || busy0 !== 1'b0 || rerr0 !== rangeModel) begin
      fails++;
      $display("FAIL basic_end actual done=%0d busy=%b rerr=%b required done=%0d busy=0 rerr=%b",
               (dq0.size() > 0) ? dq0[0] : -1, busy0, rerr0, expDoneQ[0], rangeModel);
    end
  endtask

  task automatic test_back_to_back();
    int k, k2;
    clear_all();
    pulse(1'b0, 59, 59, 23, k);
    @(negedge clk);
    pulse(1'b0, 0, 0, 0, k2);
    push_exp(59, 59, 23, k, 0);
    push_exp(0, 0, 0, k + 7, 0);
    repeat (20) @(negedge clk);
    tests++;
    if (wq0.size() != expQ.size() || dq0.size() != expDoneQ.size()) begin
      fails++;
      $display("FAIL b2b_count actual writes=%0d dones=%0d required writes=%0d dones=%0d",
               wq0.size(), dq0.size(), expQ.size(), expDoneQ.size());
    end
    for (int i = 0; i < expQ.size(); i++) begin
      tests++;
      if (i >= wq0.size() || wq0[i] !== expQ[i]) begin
        fails++;
        $display("FAIL b2b_write%0d actual cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                 i, wq0[i].cyc, wq0[i].addr, wq0[i].data, expQ[i].cyc, expQ[i].addr, expQ[i].data);
      end
    end
    for (int i = 0; i < expDoneQ.size(); i++) begin
      tests++;
      if (i >= dq0.size() || dq0[i] != expDoneQ[i]) begin
        fails++; $display("FAIL b2b_done%0d actual=%0d required=%0d", i, dq0[i], expDoneQ[i]);
      end
    end
  endtask

  task automatic test_triple_pending();
    int k, kx, v[4][3];
    clear_all();
    for (int i = 0; i < 4; i++) begin
      v[i][0] = $urandom_range(59); v[i][1] = $urandom_range(59); v[i][2] = $urandom_range(23);
    end
    pulse(1'b0, v[0][0], v[0][1], v[0][2], k);
    for (int i = 1; i < 4; i++) pulse(1'b0, v[i][0], v[i][1], v[i][2], kx);
    push_exp(v[0][0], v[0][1], v[0][2], k, 0);
    push_exp(v[3][0], v[3][1], v[3][2], k + 7, 0);
    repeat (20) @(negedge clk);
    tests++;
    if (wq0.size() != expQ.size() || dq0.size() != expDoneQ.size()) begin
      fails++;
      $display("FAIL triple_count actual writes=%0d dones=%0d required writes=%0d dones=%0d",
               wq0.size(), dq0.size(), expQ.size(), expDoneQ.size());
    end
    for (int i = 0; i < expQ.size(); i++) begin
      tests++;
      if (i >= wq0.size() || wq0[i] !== expQ[i]) begin
        fails++;
        $display("FAIL triple_write%0d actual cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                 i, wq0[i].cyc, wq0[i].addr, wq0[i].data, expQ[i].cyc, expQ[i].addr, expQ[i].data);
      end
    end
    tests++;
    if (rerr0 !== rangeModel) begin
      fails++; $display("FAIL triple_rerr actual=%b required=%b", rerr0, rangeModel);
    end
  endtask

  task automatic test_range();
    int k;
    int vals[2][3] = '{'{60, 12, 24}, '{10, 10, 10}};
    for (int r = 0; r < 2; r++) begin
      clear_all();
      pulse(1'b0, vals[r][0], vals[r][1], vals[r][2], k);
      push_exp(vals[r][0], vals[r][1], vals[r][2], k, 0);
      repeat (10) @(negedge clk);
      tests++;
      if (wq0.size() != expQ.size()) begin
        fails++; $display("FAIL range%0d_count actual=%0d required=%0d", r, wq0.size(), expQ.size());
      end
      for (int i = 0; i < expQ.size(); i++) begin
        tests++;
        if (i >= wq0.size() || wq0[i] !== expQ[i]) begin
          fails++;
          $display("FAIL range%0d_write%0d actual cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                   r, i, wq0[i].cyc, wq0[i].addr, wq0[i].data, expQ[i].cyc, expQ[i].addr, expQ[i].data);
        end
      end
      tests++;
      if (rerr0 !== rangeModel) begin
        fails++; $display("FAIL range%0d_rerr actual=%b required=%b", r, rerr0, rangeModel);
      end
    end
  endtask

  task automatic test_random();
    int k, s, m, h;
    for (int it = 0; it < 12; it++) begin
      clear_all();
      s = $urandom_range(63); m = $urandom_range(63); h = $urandom_range(31);
      pulse(1'b0, s, m, h, k);
      push_exp(s, m, h, k, 0);
      repeat (10) @(negedge clk);
      tests++;
      if (wq0.size() != expQ.size() || dq0.size() != 1 || dq0[0] != expDoneQ[0]) begin
        fails++;
        $display("FAIL rand%0d_count actual writes=%0d done=%0d required writes=6 done=%0d",
                 it, wq0.size(), (dq0.size() > 0) ? dq0[0] : -1, expDoneQ[0]);
      end
      for (int i = 0; i < expQ.size(); i++) begin
        tests++;
        if (i >= wq0.size() || wq0[i] !== expQ[i]) begin
          fails++;
          $display("FAIL rand%0d_write%0d (%0d,%0d,%0d) actual cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                   it, i, s, m, h, wq0[i].cyc, wq0[i].addr, wq0[i].data, expQ[i].cyc, expQ[i].addr, expQ[i].data);
        end
      end
      tests++;
      if (rerr0 !== rangeModel) begin
        fails++; $display("FAIL rand%0d_rerr actual=%b required=%b", it, rerr0, rangeModel);
      end
    end
  endtask

  task automatic test_gap();
    int k, s, m;
    clear_all();
    s = $urandom_range(59); m = $urandom_range(59);
    pulse(1'b1, s, m, 9, k);
    push_exp(s, m, 9, k, 3);
    repeat (28) @(negedge clk);
    tests++;
    if (wq3.size() != expQ.size() || dq3.size() != 1 || dq3[0] != expDoneQ[0]) begin
      fails++;
      $display("FAIL gap_count actual writes=%0d done=%0d required writes=6 done=%0d",
               wq3.size(), (dq3.size() > 0) ? dq3[0] : -1, expDoneQ[0]);
    end
    for (int i = 0; i < expQ.size(); i++) begin
      tests++;
      if (i >= wq3.size() || wq3[i] !== expQ[i]) begin
        fails++;
        $display("FAIL gap_write%0d actual cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                 i, wq3[i].cyc, wq3[i].addr, wq3[i].data, expQ[i].cyc, expQ[i].addr, expQ[i].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k, kx;
    clear_all();
    pulse(1'b0, 11, 22, 3, k);
    pulse(1'b0, 44, 33, 12, kx);
    @(negedge clk);
    tests++;
    if ({cs0, addr0} !== {1'b0, 3'd2}) begin
      fails++; $display("FAIL rstmid_pre actual cs=%b addr=%0d required cs=0 addr=2", cs0, addr0);
    end
    rst_n = 1'b0;
    #1;
    rangeModel = 1'b0;
    tests++;
    if ({cs0, wr0, addr0, busy0, done0, rerr0} !== {1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0} || data0 !== 32'd0) begin
      fails++;
      $display("FAIL rstmid_async actual cs=%b wr=%b addr=%0d data=%h busy=%b rerr=%b required 1 1 0 0 0 0",
               cs0, wr0, addr0, data0, busy0, rerr0);
    end
    @(negedge clk);
    clear_all();
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    tests++;
    if (wq0.size() != 0 || dq0.size() != 0 || busy0 !== 1'b0 || rerr0 !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_after actual writes=%0d dones=%0d busy=%b rerr=%b required 0 0 0 0",
               wq0.size(), dq0.size(), busy0, rerr0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_triple_pending();
    test_range();
    test_random();
    test_gap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
